// File: rtl/neuron_link_pkg.sv
// Shared constants and FSM encodings for the neuron 4-phase byte link host.
package neuron_link_pkg;

  localparam int LINK_DATA_W     = 8;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SETUP = 2'd1,
    TX_REQ   = 2'd2,
    TX_REL   = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_WAIT = 2'd0,
    RX_ACK  = 2'd1,
    RX_DROP = 2'd2
  } rx_state_e;

endpackage

// File: rtl/neuron_link_host_if.sv
// Byte source/sink and tile-pin signals of the link host. master = host side, slave = tile/environment side.
interface neuron_link_host_if;
  import neuron_link_pkg::*;

  logic [LINK_DATA_W-1:0] tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic [LINK_DATA_W-1:0] rx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic [LINK_DATA_W-1:0] link_data;
  logic                   link_req;
  logic                   link_in_ack;
  logic                   link_out_req;
  logic [LINK_DATA_W-1:0] link_out_data;
  logic                   link_out_ack;

  modport master (
    input  tx_data, tx_valid, rx_ready, link_in_ack, link_out_req, link_out_data,
    output tx_ready, rx_data, rx_valid, link_data, link_req, link_out_ack
  );

  modport slave (
    output tx_data, tx_valid, rx_ready, link_in_ack, link_out_req, link_out_data,
    input  tx_ready, rx_data, rx_valid, link_data, link_req, link_out_ack
  );

endinterface

// File: rtl/neuron_link_sync.sv
// Multi-flop synchroniser for asynchronous link inputs; all stages reset to 0.
module neuron_link_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) stage_d[i] = stage_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/neuron_link_host.sv
// Host-side initiator/responder for the neuron 4-phase req/ack byte link.
// LINK_TIMEOUT_EN enables the handshake timeout counters and the sticky err flag.
//   TX state | meaning                    RX state | meaning
//   IDLE     | ready for a source byte    WAIT     | waiting for tile req + buffer space
//   SETUP    | data on pins, req low      ACK      | byte captured, ack high
//   REQ      | req high, awaiting ack     DROP     | one-cycle guard after ack falls
//   REL      | req low, awaiting ack low
module neuron_link_host
  import neuron_link_pkg::*;
#(
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic err_clr,
  output logic err,
  neuron_link_host_if.master lnk
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic                   ack_s;
  logic                   oreq_s;
  logic [LINK_DATA_W-1:0] odata_s;

  neuron_link_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_ack (
    .clk(clk), .rst_n(rst_n), .d(lnk.link_in_ack), .q(ack_s)
  );
  neuron_link_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_oreq (
    .clk(clk), .rst_n(rst_n), .d(lnk.link_out_req), .q(oreq_s)
  );
  neuron_link_sync #(.WIDTH(LINK_DATA_W), .STAGES(SYNC_STAGES)) u_sync_odata (
    .clk(clk), .rst_n(rst_n), .d(lnk.link_out_data), .q(odata_s)
  );

  tx_state_e              tx_state_q, tx_state_d;
  logic [LINK_DATA_W-1:0] link_data_q, link_data_d;
  logic                   link_req_q, link_req_d;
  rx_state_e              rx_state_q, rx_state_d;
  logic [LINK_DATA_W-1:0] rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   out_ack_q, out_ack_d;
  logic                   tx_tmo, rx_tmo;
  logic                   tx_ready_w;

  assign tx_ready_w = (tx_state_q == TX_IDLE) && ena && !ack_s;

  always_comb begin
    tx_state_d  = tx_state_q;
    link_data_d = link_data_q;
    link_req_d  = link_req_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (lnk.tx_valid && tx_ready_w) begin
          link_data_d = lnk.tx_data;
          tx_state_d  = TX_SETUP;
        end
      end
      TX_SETUP: begin
        tx_state_d = TX_REQ;
        link_req_d = 1'b1;
      end
      TX_REQ: begin
        if (tx_tmo) begin
          tx_state_d = TX_IDLE;
          link_req_d = 1'b0;
        end else if (ack_s) begin
          tx_state_d = TX_REL;
          link_req_d = 1'b0;
        end
      end
      TX_REL: begin
        if (tx_tmo || !ack_s) tx_state_d = TX_IDLE;
      end
      default: begin
        tx_state_d = TX_IDLE;
        link_req_d = 1'b0;
      end
    endcase
  end

  // A pop and a capture on the same edge leave rx_valid set with the new byte.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q && !lnk.rx_ready;
    out_ack_d  = out_ack_q;
    unique case (rx_state_q)
      RX_WAIT: begin
        if (oreq_s && ena && (!rx_valid_q || lnk.rx_ready)) begin
          rx_state_d = RX_ACK;
          rx_data_d  = odata_s;
          rx_valid_d = 1'b1;
          out_ack_d  = 1'b1;
        end
      end
      RX_ACK: begin
        if (rx_tmo || !oreq_s) begin
          rx_state_d = RX_DROP;
          out_ack_d  = 1'b0;
        end
      end
      RX_DROP: rx_state_d = RX_WAIT;
      default: begin
        rx_state_d = RX_WAIT;
        out_ack_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= TX_IDLE;
      link_data_q <= '0;
      link_req_q  <= 1'b0;
      rx_state_q  <= RX_WAIT;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      out_ack_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      link_data_q <= link_data_d;
      link_req_q  <= link_req_d;
      rx_state_q  <= rx_state_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      out_ack_q   <= out_ack_d;
    end
  end

`ifdef LINK_TIMEOUT_EN
  localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [TMO_W-1:0] rx_cnt_q, rx_cnt_d;
  logic             err_q, err_d;
  logic             tx_active, rx_active;

  // Down-counters reload on every state change; terminal count is zero.
  assign tx_active = (tx_state_q == TX_REQ) || (tx_state_q == TX_REL);
  assign rx_active = (rx_state_q == RX_ACK);
  assign tx_tmo    = tx_active && (tx_cnt_q == '0);
  assign rx_tmo    = rx_active && (rx_cnt_q == '0);

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    if (tx_state_d != tx_state_q) tx_cnt_d = TMO_LOAD;
    else if (tx_active)           tx_cnt_d = tx_cnt_q - 1'b1;
    if (rx_state_d != rx_state_q) rx_cnt_d = TMO_LOAD;
    else if (rx_active)           rx_cnt_d = rx_cnt_q - 1'b1;
    err_d = (err_q && !err_clr) || tx_tmo || rx_tmo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt_q <= TMO_LOAD;
      rx_cnt_q <= TMO_LOAD;
      err_q    <= 1'b0;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign tx_tmo         = 1'b0;
  assign rx_tmo         = 1'b0;
  assign err            = 1'b0;
`endif

  assign lnk.tx_ready     = tx_ready_w;
  assign lnk.link_data    = link_data_q;
  assign lnk.link_req     = link_req_q;
  assign lnk.rx_data      = rx_data_q;
  assign lnk.rx_valid     = rx_valid_q;
  assign lnk.link_out_ack = out_ack_q;

endmodule
